io_serializer: RTL
==================

# io_serializer

Parallel-to-serial output stage that feeds the OUT and TS inputs of an I/O block configured for TS-controlled output (TSMUX = 2'b01, TS = 1 drives PIN). It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per IOCLK. It holds TS high only while bits are on the wire, then releases the pad for a configurable turnaround guard. It sits directly upstream of the I/O block, in the IOCLK domain.

## Interface
- WIDTH, 8, data word width; legal range 2..32.
- GUARD, 1, turnaround cycles with TS low after each word; legal range 0..15.

- IOCLK  in  1  I/O clock; all state changes on its rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- DIN  in  WIDTH  parallel word to transmit.
- DVALID  in  1  DIN is valid.
- DREADY  out  1  block can accept a word; a transfer occurs on a rising edge with DVALID & DREADY.
- OUT  out  1  serial data to the I/O block OUT input.
- TS  out  1  output enable to the I/O block TS input; 1 = pad driven.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse after the last wire bit.

## Operation
- All outputs are registered. Reset values: DREADY=1, OUT=0, TS=0, BUSY=0, DONE=0. State=IDLE, shift register=0, counters=0.
- The FSM has four states:
  - IDLE: DREADY=1, TS=0, OUT=0.
    - On accept, load DIN into the shift register, set the bit counter to WIDTH-1, and go to SHIFT.
    - DIN is ignored when no accept occurs.
  - SHIFT: TS=1, OUT=shreg[WIDTH-1]; shift left by one each cycle and decrement the counter.
    - When the counter reaches 0, go to PARITY if it is compiled in.
    - Otherwise go to GUARD, or to IDLE when GUARD=0.
  - PARITY (only when IOSER_PARITY_EN is defined): TS=1, OUT = parity bit (see Configuration). Lasts one cycle, then goes to GUARD, or to IDLE when GUARD=0.
  - GUARD: TS=0, OUT=0. Lasts exactly GUARD cycles, counted by a 4-bit down-counter, then goes to IDLE.
- DONE is high for exactly one cycle: the first cycle after the last wire bit, whether that cycle is in GUARD or IDLE.
- DREADY is 1 only in IDLE. Back-to-back words are therefore separated by at least one IDLE cycle with TS=0.
- DIN and DVALID are sampled only in IDLE. Changes to DIN during SHIFT do not affect the word in flight.
- Reset asserted mid-word aborts the transfer immediately: TS=0 and OUT=0 asynchronously, with no DONE pulse. After RSTN deasserts, the block starts in IDLE.

## Timing
- Accept at edge k: the MSB appears on OUT with TS=1 in the cycle following edge k.
- Bit i (0 = MSB) is valid during cycle k+1+i.
- Wire bits per word: N = WIDTH, or WIDTH+1 with parity.
- TS is high for exactly N consecutive cycles, k+1 .. k+N.
- DONE and the first TS=0 cycle occur at cycle k+N+1.
- DREADY reasserts at cycle k+N+1+GUARD.
- Word period with DVALID held high: N+GUARD+1 cycles.
- TS never glitches high outside SHIFT or PARITY; TS and OUT change on the same edge.

## Configuration
- IOSER_PARITY_EN:
  - Defined: the PARITY state exists. The bit appended after the LSB is XOR of the WIDTH data bits (even parity), computed from DIN at accept time.
  - Undefined: no PARITY state. Transmission ends at the LSB, and the parity logic is absent.

## Test plan
- Reset defaults: RSTN=0 then release → DREADY=1, TS=0, OUT=0, BUSY=0, DONE=0.
- WIDTH=8, GUARD=1, no parity, DIN=8'hA5 accepted at edge k → OUT=1,0,1,0,0,1,0,1 over cycles k+1..k+8 with TS=1; DONE=1 and TS=0 at k+9; DREADY=1 at k+10.
- Parity build, DIN=8'h07 → 8 data bits, then OUT=1 with TS=1 at k+9; DONE at k+10. With DIN=8'hA5 the parity bit is 0.
- GUARD=0, DVALID held high with DIN=8'h3C then 8'hC3 → the two words are separated by exactly one TS=0 cycle (the IDLE accept cycle); DONE pulses once per word.
- RSTN pulsed low at the 4th bit of 8'hFF → TS=0 immediately, no DONE; the next word after release transmits correctly from its MSB.
- DIN toggled randomly during SHIFT with DVALID=1 → OUT matches only the word captured at accept; DREADY stays 0 until IDLE.

Source files
------------

// File: rtl/io_serializer_if.sv
// io_serializer_if: word handshake plus serial pad-side signals of io_serializer.
// master = upstream word source / pad consumer, slave = io_serializer.
interface io_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             dvalid;
  logic             dready;
  logic             out;
  logic             ts;
  logic             busy;
  logic             done;

  modport master (
    output din,
    output dvalid,
    input  dready,
    input  out,
    input  ts,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  dvalid,
    output dready,
    output out,
    output ts,
    output busy,
    output done
  );
endinterface

// File: rtl/io_serializer.sv
// io_serializer: MSB-first parallel-to-serial stage driving the OUT/TS pair of a
// TS-controlled I/O block. TS is high only while bits are on the wire, followed
// by GUARD turnaround cycles with the pad released.
// Optional feature: define IOSER_PARITY_EN to append an even-parity bit after the LSB.
module io_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GUARD = 1
) (
  input  logic          IOCLK,
  input  logic          RSTN,
  io_serializer_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GRD_LAST = 4'((GUARD == 0) ? 0 : GUARD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GUARD  = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] shreg_q, shreg_nxt;
  logic [CW-1:0]    bitcnt_q, bitcnt_nxt;
  logic [3:0]       gcnt_q, gcnt_nxt;
  logic             accept;

  logic dready_d, out_d, ts_d, busy_d, done_d;
  logic dready_q, out_q, ts_q, busy_q, done_q;

`ifdef IOSER_PARITY_EN
  logic par_q, par_nxt;
`endif

  // A word is taken only from IDLE; DREADY mirrors that registered state.
  assign accept = (state_q == S_IDLE) && bus.dvalid;

  // State register.
  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (bitcnt_q == '0) begin
`ifdef IOSER_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = (GUARD == 0) ? S_IDLE : S_GUARD;
`endif
        end
      end
      S_PARITY: begin
        state_nxt = (GUARD == 0) ? S_IDLE : S_GUARD;
      end
      S_GUARD: begin
        if (gcnt_q == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values: shift register, bit counter, guard counter, parity.
  always_comb begin
    shreg_nxt  = shreg_q;
    bitcnt_nxt = bitcnt_q;
    gcnt_nxt   = gcnt_q;
`ifdef IOSER_PARITY_EN
    par_nxt    = par_q;
`endif
    if (accept) begin
      shreg_nxt  = bus.din;
      bitcnt_nxt = BIT_LAST;
`ifdef IOSER_PARITY_EN
      par_nxt    = ^bus.din;
`endif
    end else if (state_q == S_SHIFT) begin
      shreg_nxt = {shreg_q[WIDTH-2:0], 1'b0};
      if (bitcnt_q != '0) bitcnt_nxt = bitcnt_q - CW'(1);
    end
    if ((state_nxt == S_GUARD) && (state_q != S_GUARD)) begin
      gcnt_nxt = GRD_LAST;
    end else if ((state_q == S_GUARD) && (gcnt_q != '0)) begin
      gcnt_nxt = gcnt_q - 4'd1;
    end
  end

  // Output decode from the upcoming state so the pad outputs can be registered.
  always_comb begin
    dready_d = (state_nxt == S_IDLE);
    busy_d   = (state_nxt != S_IDLE);
    ts_d     = 1'b0;
    out_d    = 1'b0;
    case (state_nxt)
      S_SHIFT: begin
        ts_d  = 1'b1;
        out_d = shreg_nxt[WIDTH-1];
      end
`ifdef IOSER_PARITY_EN
      S_PARITY: begin
        ts_d  = 1'b1;
        out_d = par_nxt;
      end
`endif
      default: begin
        ts_d  = 1'b0;
        out_d = 1'b0;
      end
    endcase
    // Last wire bit just left the pad.
    done_d = ts_q && !ts_d;
  end

  // Datapath and output registers; reset drops TS/OUT immediately.
  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gcnt_q   <= '0;
      dready_q <= 1'b1;
      out_q    <= 1'b0;
      ts_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_nxt;
      bitcnt_q <= bitcnt_nxt;
      gcnt_q   <= gcnt_nxt;
      dready_q <= dready_d;
      out_q    <= out_d;
      ts_q     <= ts_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef IOSER_PARITY_EN
  // Parity bit captured at accept time.
  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) par_q <= 1'b0;
    else       par_q <= par_nxt;
  end
`endif

  assign bus.dready = dready_q;
  assign bus.out    = out_q;
  assign bus.ts     = ts_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
